// File: rtl/bcd_pkg.sv
// Shared BCD arithmetic constants and sequencer state encoding for the
// decimal datapath (adder and subtractor).
package bcd_pkg;

   localparam int BCD_W   = 4;
   localparam int BCD_MAX = 9;
   localparam int BCD_ADJ = 6;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/bcd_digit_adder.sv
// Combinational single-digit BCD add with carry; companion of the
// single-digit BCD subtractor.
module bcd_digit_adder
   import bcd_pkg::*;
(
   input  logic [BCD_W-1:0] i_a,
   input  logic [BCD_W-1:0] i_b,
   input  logic             i_carry,
   output logic [BCD_W-1:0] o_digit,
   output logic             o_carry,
   output logic             o_invalid
);

   logic [BCD_W:0]   w_sum;
   logic [BCD_W-1:0] w_adj;

   assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {{BCD_W{1'b0}}, i_carry};
   // Only the low nibble of s+6 is kept, so the adjust can be done 4 bits wide.
   assign w_adj = w_sum[BCD_W-1:0] + BCD_W'(BCD_ADJ);

   assign o_carry   = (w_sum > (BCD_W+1)'(BCD_MAX));
   assign o_digit   = o_carry ? w_adj : w_sum[BCD_W-1:0];
   assign o_invalid = (i_a > BCD_W'(BCD_MAX)) || (i_b > BCD_W'(BCD_MAX));

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit BCD adder, one digit per clock LSD first, with the ripple
// carry held in a register and a start/busy/done handshake.
module bcd_serial_adder
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
)
(
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic [BCD_W*DIGITS-1:0] a_i,
   input  logic [BCD_W*DIGITS-1:0] b_i,
   input  logic                    carry_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic [BCD_W*DIGITS-1:0] sum_o,
   output logic                    carry_o,
   output logic                    invalid_o
);

   localparam int W     = BCD_W * DIGITS;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_t           r_state;
   logic [W-1:0]     r_a;
   logic [W-1:0]     r_b;
   logic [W-1:0]     r_sum;
   logic             r_carry;
   logic             r_inv;
   logic [IDX_W-1:0] r_idx;
   logic             r_busy;
   logic             r_done;
   logic [W-1:0]     r_sum_out;
   logic             r_carry_out;
   logic             r_inv_out;

   logic [BCD_W-1:0] w_a_dig;
   logic [BCD_W-1:0] w_b_dig;
   logic [BCD_W-1:0] w_digit;
   logic             w_cout;
   logic             w_dig_inv;
   logic             w_inv_acc;
   logic             w_last;
   logic [W-1:0]     w_sum_next;

   assign w_a_dig   = r_a[BCD_W*r_idx +: BCD_W];
   assign w_b_dig   = r_b[BCD_W*r_idx +: BCD_W];
   assign w_inv_acc = r_inv | w_dig_inv;
   assign w_last    = (r_idx == IDX_W'(DIGITS - 1));

   bcd_digit_adder u_digit (
      .i_a       (w_a_dig),
      .i_b       (w_b_dig),
      .i_carry   (r_carry),
      .o_digit   (w_digit),
      .o_carry   (w_cout),
      .o_invalid (w_dig_inv)
   );

   // Internal sum with the current digit merged in, so the completion edge
   // can publish the full result including the last digit.
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_sum
      assign w_sum_next[BCD_W*gi +: BCD_W] =
         (r_idx == IDX_W'(gi)) ? w_digit : r_sum[BCD_W*gi +: BCD_W];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_sum       <= '0;
         r_carry     <= 1'b0;
         r_inv       <= 1'b0;
         r_idx       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_sum_out   <= '0;
         r_carry_out <= 1'b0;
         r_inv_out   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_a     <= a_i;
                  r_b     <= b_i;
                  r_carry <= carry_i;
                  r_idx   <= '0;
                  r_inv   <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_sum   <= w_sum_next;
               r_carry <= w_cout;
               r_inv   <= w_inv_acc;
               r_idx   <= r_idx + IDX_W'(1);
               if (w_last) begin
                  r_sum_out   <= w_sum_next;
                  r_carry_out <= w_cout;
                  r_inv_out   <= w_inv_acc;
                  r_done      <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy_o    = r_busy;
   assign done_o    = r_done;
   assign sum_o     = r_sum_out;
   assign carry_o   = r_carry_out;
   assign invalid_o = r_inv_out;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed bench for bcd_serial_adder (DIGITS=4): vector table plus
// hand-written handshake, reset and back-to-back sequences.
module tb_bcd_serial_adder;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        busy;
   logic        done;
   logic [15:0] sum;
   logic        cout;
   logic        inv;

   int n_vec;
   int n_miss;
   logic [15:0] prev_sum;
   logic        prev_cout;
   logic        prev_inv;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] sum;
      logic        cout;
      logic        inv;
   } vec_t;

   vec_t vecs [10];

   bcd_serial_adder #(.DIGITS(4)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .start_i   (start),
      .a_i       (a),
      .b_i       (b),
      .carry_i   (cin),
      .busy_o    (busy),
      .done_o    (done),
      .sum_o     (sum),
      .carry_o   (cout),
      .invalid_o (inv)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one operation at a negedge and follow it to completion. Operands
   // are scrambled right after the accepting edge; the result must not care.
   task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic vc, input logic [15:0] es, input logic ec, input logic ei);
      int cyc;
      a = va; b = vb; cin = vc; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; a = 16'hFFFF; b = 16'hFFFF; cin = ~vc;
      cyc = 1;
      while (!done && cyc < 20) begin
         check({tag, " busy"}, {31'd0, busy}, 32'd1);
         check({tag, " hold"}, {15'd0, inv, cout, sum}, {15'd0, prev_inv, prev_cout, prev_sum});
         @(negedge clk);
         cyc++;
      end
      check({tag, " latency"}, cyc, 32'd5);
      check({tag, " busy@done"}, {31'd0, busy}, 32'd0);
      check({tag, " result"}, {15'd0, inv, cout, sum}, {15'd0, ei, ec, es});
      prev_sum = es; prev_cout = ec; prev_inv = ei;
      $display("op %s: %h + %h + %0d -> sum=%h carry=%0d invalid=%0d", tag, va, vb, vc, sum, cout, inv);
      @(negedge clk);
      check({tag, " done pulse"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      logic [15:0] mask;
      int          cyc;
      n_vec = 0; n_miss = 0;
      prev_sum = '0; prev_cout = 1'b0; prev_inv = 1'b0;

      vecs[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
      vecs[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
      vecs[3] = '{16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1};
      vecs[4] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
      vecs[5] = '{16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[6] = '{16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
      vecs[7] = '{16'h4567, 16'h0000, 1'b1, 16'h4568, 1'b0, 1'b0};
      vecs[8] = '{16'hF000, 16'h0000, 1'b0, 16'h5000, 1'b1, 1'b1};
      vecs[9] = '{16'h2468, 16'h1357, 1'b0, 16'h3825, 1'b0, 1'b0};

      // Reset held for two cycles with start asserted.
      rst = 1'b1; start = 1'b1; a = 16'h1234; b = 16'h5678; cin = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("reset outputs", {12'd0, busy, done, cout, inv, sum}, 32'd0);
      end
      start = 1'b0; rst = 1'b0;
      @(negedge clk);
      check("post-reset idle", {30'd0, busy, done}, 32'd0);

      for (int i = 0; i < 10; i++)
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                vecs[i].sum, vecs[i].cout, vecs[i].inv);

      // Start during RUN is ignored and not queued.
      a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 16'h1111; b = 16'h1111; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 3;
      while (!done && cyc < 20) begin @(negedge clk); cyc++; end
      check("ignore latency", cyc, 32'd5);
      check("ignore result", {16'd0, sum}, 32'h6912);
      $display("op ignore-start: sum=%h", sum);
      @(negedge clk);
      check("ignore no queue", {30'd0, busy, done}, 32'd0);

      // Start held high: back-to-back results every 5 cycles.
      a = 16'h0001; b = 16'h0002; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      mask = '0;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         if (c == 11) start = 1'b0;
         if (done) mask[c] = 1'b1;
         if (c == 5 || c == 10) check("b2b busy@done", {31'd0, busy}, 32'd0);
         if (c == 6) check("b2b restart busy", {31'd0, busy}, 32'd1);
      end
      check("b2b done cycles", {16'd0, mask}, 32'h8420);
      check("b2b result", {16'd0, sum}, 32'h0003);
      $display("op back-to-back: done mask=%h sum=%h", mask, sum);

      // Reset after E2 discards the operation.
      @(negedge clk);
      a = 16'h1234; b = 16'h5678; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midreset idle", {30'd0, busy, done}, 32'd0);
      check("midreset sum", {15'd0, inv, cout, sum}, 32'd0);
      mask = '0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (done || busy) mask[c] = 1'b1;
      end
      check("midreset quiet", {16'd0, mask}, 32'd0);
      $display("op mid-reset: sum=%h busy=%0d", sum, busy);
      prev_sum = '0; prev_cout = 1'b0; prev_inv = 1'b0;
      run_op("after-reset", 16'h0042, 16'h0058, 1'b0, 16'h0100, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
